// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default datapath widths and the fetch FSM encoding.
package cpu_pkg;

  localparam int DATA_W_DEF    = 32;
  localparam int PC_W_DEF      = 32;
  localparam int ADDR_BITS_DEF = 10;

  // Fetch FSM state encoding.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FETCH  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of {pc, instr} entries between fetch and decode.
// The head entry is presented directly; zeros are shown when the queue is empty.
module fetch_queue #(
  parameter int  DEPTH   = 2,
  parameter int  ENTRY_W = 64,
  localparam int CNT_W   = $clog2(DEPTH + 1),
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic [ENTRY_W-1:0] push_data,
  output logic [CNT_W-1:0]   count,
  output logic               head_valid,
  output logic [ENTRY_W-1:0] head_data
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Guard the requests so count can never leave 0..DEPTH.
  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q < CNT_W'(DEPTH)) || do_pop);

  // Next-state for storage, pointers and occupancy; flush overrides push/pop.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) begin
        mem_d[tail_q] = push_data;
        tail_d        = ptr_inc(tail_q);
      end
      if (do_pop) begin
        head_d = ptr_inc(head_q);
      end
      if (do_push && !do_pop) begin
        count_d = count_q + 1'b1;
      end else if (do_pop && !do_push) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (reset) begin
      // NOTE: the storage array is cleared on reset as well, so the queue contents are never unknown.
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign count      = count_q;
  assign head_valid = (count_q != '0);
  assign head_data  = head_valid ? mem_q[head_q] : '0;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register and IDLE/FETCH/HALTED control, feeding
// a small queue toward decode. Talks to instruction memory only via F_PC/Instr.
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int PC_W      = PC_W_DEF,
  parameter int ADDR_BITS = ADDR_BITS_DEF,
  parameter int QDEPTH    = 2,
  parameter int RESET_PC  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              halt_req,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic [PC_W-1:0]   F_PC,
  input  logic [DATA_W-1:0] Instr,
  output logic              D_valid,
  input  logic              D_ready,
  output logic [DATA_W-1:0] D_instr,
  output logic [PC_W-1:0]   D_pc,
  output logic              busy
);

  localparam int CNT_W = $clog2(QDEPTH + 1);

  logic [1:0]             state_q, state_d;
  logic [ADDR_BITS-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]       q_count;
  logic [PC_W+DATA_W-1:0] q_head;
  logic                   pop, fetch, redirect_take;
  logic                   unused_redirect_pc;

  // Only the low ADDR_BITS of a redirect target address memory; the rest are dropped.
  assign unused_redirect_pc = ^redirect_pc;

  // F_PC comes straight from the pc register, zero-extended: no input-to-output path.
  assign F_PC          = PC_W'(pc_q);
  assign pop           = D_valid && D_ready;
  assign redirect_take = redirect_valid && (state_q != ST_IDLE);
  assign fetch         = (state_q == ST_FETCH) && !halt_req && !redirect_valid &&
                         ((q_count < CNT_W'(QDEPTH)) || pop);

  // FSM and pc next-state; a redirect outranks halt and fetch in the same cycle.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_FETCH;
      ST_FETCH:  if (!redirect_valid && halt_req) state_d = ST_HALTED;
      ST_HALTED: if (redirect_valid) state_d = ST_FETCH;
      default:   state_d = ST_IDLE;
    endcase
    if (redirect_take) begin
      pc_d = redirect_pc[ADDR_BITS-1:0];
    end else if (fetch) begin
      pc_d = pc_q + 1'b1;
    end
  end

  // State and pc registers; reset outranks every other event.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= ADDR_BITS'(RESET_PC);
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // A pop in a redirect cycle still completes; the flush drops what remains.
  fetch_queue #(
    .DEPTH   (QDEPTH),
    .ENTRY_W (PC_W + DATA_W)
  ) u_fetch_queue (
    .clk        (clk),
    .reset      (reset),
    .push       (fetch),
    .pop        (pop),
    .flush      (redirect_take),
    .push_data  ({F_PC, Instr}),
    .count      (q_count),
    .head_valid (D_valid),
    .head_data  (q_head)
  );

  assign {D_pc, D_instr} = q_head;
  assign busy            = (state_q == ST_FETCH) || D_valid;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a table of per-cycle vectors with
// hand-computed outputs, then a randomised-backpressure ordering sequence.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset, start, halt_req, redirect_valid, d_ready;
  logic [31:0] redirect_pc;
  logic [31:0] f_pc, instr, d_instr, d_pc;
  logic        d_valid, busy;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        rst, st, hlt, rv, rdy;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc, einstr, efpc;
    logic        eb;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  // Memory contents: word a holds 0xA0 + a (so words 0..3 are 0xA0..0xA3).
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'hA0 + {22'b0, a[9:0]};
  endfunction

  assign instr = word_at(f_pc);

  instruction_fetch dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .halt_req       (halt_req),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .F_PC           (f_pc),
    .Instr          (instr),
    .D_valid        (d_valid),
    .D_ready        (d_ready),
    .D_instr        (d_instr),
    .D_pc           (d_pc),
    .busy           (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t v(input logic rst, st, hlt, rv, input logic [31:0] rpc,
                             input logic rdy, ev, input logic [31:0] epc, efpc,
                             input logic eb);
    vec_t r;
    r.rst = rst; r.st = st; r.hlt = hlt; r.rv = rv; r.rpc = rpc; r.rdy = rdy;
    r.ev = ev; r.epc = epc; r.efpc = efpc; r.eb = eb;
    r.einstr = ev ? word_at(epc) : 32'h0;
    return r;
  endfunction

  task automatic drive(input logic rst, st, hlt, rv, input logic [31:0] rpc, input logic rdy);
    reset = rst; start = st; halt_req = hlt; redirect_valid = rv;
    redirect_pc = rpc; d_ready = rdy;
  endtask

  initial begin
    int exp_pc;
    int cycles;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

    //          rst st hlt rv rpc    rdy  ev epc    f_pc   busy
    // reset, then halt/redirect ignored in IDLE
    vecs.push_back(v(1, 0, 0, 0, 0,     0,   0, 0,     0,     0));
    vecs.push_back(v(0, 0, 1, 1, 7,     1,   0, 0,     0,     0));
    // stream 0/A0, 1/A1, 2/A2 (start ignored in FETCH)
    vecs.push_back(v(0, 1, 0, 0, 0,     1,   0, 0,     0,     1));
    vecs.push_back(v(0, 0, 0, 0, 0,     1,   1, 0,     1,     1));
    vecs.push_back(v(0, 1, 0, 0, 0,     1,   1, 1,     2,     1));
    vecs.push_back(v(0, 0, 0, 0, 0,     1,   1, 2,     3,     1));
    // backpressure: 5 cycles of D_ready=0, queue fills, F_PC freezes at 2
    vecs.push_back(v(1, 0, 0, 0, 0,     1,   0, 0,     0,     0));
    vecs.push_back(v(0, 1, 0, 0, 0,     0,   0, 0,     0,     1));
    vecs.push_back(v(0, 0, 0, 0, 0,     0,   1, 0,     1,     1));
    vecs.push_back(v(0, 0, 0, 0, 0,     0,   1, 0,     2,     1));
    vecs.push_back(v(0, 0, 0, 0, 0,     0,   1, 0,     2,     1));
    vecs.push_back(v(0, 0, 0, 0, 0,     0,   1, 0,     2,     1));
    vecs.push_back(v(0, 0, 0, 0, 0,     1,   1, 1,     3,     1));
    vecs.push_back(v(0, 0, 0, 0, 0,     1,   1, 2,     4,     1));
    vecs.push_back(v(0, 0, 0, 0, 0,     1,   1, 3,     5,     1));
    // redirect to 0x10 with a full queue and a pop in the same cycle
    vecs.push_back(v(0, 0, 0, 1, 'h10,  1,   0, 0,     'h10,  1));
    vecs.push_back(v(0, 0, 0, 0, 0,     1,   1, 'h10,  'h11,  1));
    vecs.push_back(v(0, 0, 0, 0, 0,     1,   1, 'h11,  'h12,  1));
    // wrap 1022, 1023, 0, 1
    vecs.push_back(v(0, 0, 0, 1, 1022,  1,   0, 0,     1022,  1));
    vecs.push_back(v(0, 0, 0, 0, 0,     1,   1, 1022,  1023,  1));
    vecs.push_back(v(0, 0, 0, 0, 0,     1,   1, 1023,  0,     1));
    vecs.push_back(v(0, 0, 0, 0, 0,     1,   1, 0,     1,     1));
    vecs.push_back(v(0, 0, 0, 0, 0,     1,   1, 1,     2,     1));
    // halt, drain, start ignored in HALTED, redirect to 5 resumes
    vecs.push_back(v(0, 0, 1, 0, 0,     0,   1, 1,     2,     1));
    vecs.push_back(v(0, 0, 0, 0, 0,     1,   0, 0,     2,     0));
    vecs.push_back(v(0, 1, 0, 0, 0,     1,   0, 0,     2,     0));
    vecs.push_back(v(0, 0, 0, 1, 5,     1,   0, 0,     5,     1));
    vecs.push_back(v(0, 0, 0, 0, 0,     1,   1, 5,     6,     1));
    // reset mid-stream with count=2; reset outranks start/redirect/pop
    vecs.push_back(v(0, 0, 0, 0, 0,     0,   1, 5,     7,     1));
    vecs.push_back(v(1, 1, 0, 1, 9,     1,   0, 0,     0,     0));
    vecs.push_back(v(0, 0, 0, 0, 0,     1,   0, 0,     0,     0));
    vecs.push_back(v(0, 1, 0, 0, 0,     1,   0, 0,     0,     1));
    vecs.push_back(v(0, 0, 0, 0, 0,     1,   1, 0,     1,     1));
    // halt together with redirect: redirect wins, FSM stays in FETCH
    vecs.push_back(v(0, 0, 1, 1, 'h20,  1,   0, 0,     'h20,  1));
    vecs.push_back(v(0, 0, 0, 0, 0,     1,   1, 'h20,  'h21,  1));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].st, vecs[i].hlt, vecs[i].rv, vecs[i].rpc, vecs[i].rdy);
      @(posedge clk);
      #1;
      check($sformatf("v%0d.D_valid", i), {31'b0, d_valid}, {31'b0, vecs[i].ev});
      check($sformatf("v%0d.D_pc", i), d_pc, vecs[i].epc);
      check($sformatf("v%0d.D_instr", i), d_instr, vecs[i].einstr);
      check($sformatf("v%0d.F_PC", i), f_pc, vecs[i].efpc);
      check($sformatf("v%0d.busy", i), {31'b0, busy}, {31'b0, vecs[i].eb});
    end

    // Random backpressure: every accepted word must be the next address, in order.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    @(posedge clk); #1;
    start  = 1'b0;
    exp_pc = 0;
    cycles = 0;
    while (exp_pc < 20 && cycles < 400) begin
      d_ready = 1'($urandom_range(0, 1));
      if (d_valid && d_ready) begin
        check($sformatf("rnd%0d.D_pc", exp_pc), d_pc, exp_pc);
        check($sformatf("rnd%0d.D_instr", exp_pc), d_instr, word_at(exp_pc));
        exp_pc++;
      end
      @(posedge clk); #1;
      cycles++;
    end
    if (exp_pc < 20) check("rnd.timeout_transfers", exp_pc, 20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter DATA_W, default 32, the instruction width.
REQ-002 SHALL have parameter PC_W, default 32, the width of the PC port, matching the memory input bus.
REQ-003 SHALL have parameter ADDR_BITS, default 10, where the memory holds 2**ADDR_BITS words.
REQ-004 SHALL have parameter QDEPTH, default 2, the fetch queue depth.
REQ-005 SHALL have parameter RESET_PC, default 0, the start word address.
REQ-006 SHALL have port clk, input, 1 bit: the single clock, active on the rising edge.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port start, input, 1 bit: begin fetching from IDLE.
REQ-009 SHALL have port halt_req, input, 1 bit: stop fetching.
REQ-010 SHALL have port redirect_valid, input, 1 bit: branch/jump redirect.
REQ-011 SHALL have port redirect_pc, input, PC_W bits: the redirect target word address.
REQ-012 SHALL have port F_PC, output, PC_W bits: the word address driven to the instruction memory.
REQ-013 SHALL have port Instr, input, DATA_W bits: the memory data, combinationally valid in the same cycle as F_PC.
REQ-014 SHALL have port D_valid, output, 1 bit: the queue head is valid.
REQ-015 SHALL have port D_ready, input, 1 bit: the decode stage accepts the head.
REQ-016 SHALL have port D_instr, output, DATA_W bits: the queue head instruction.
REQ-017 SHALL have port D_pc, output, PC_W bits: the address of D_instr.
REQ-018 SHALL have port busy, output, 1 bit: high when the state is FETCH or the queue is not empty.

Function
REQ-019 SHALL implement the states IDLE, FETCH and HALTED.
REQ-020 SHALL transition IDLE->FETCH on start; redirect_valid and halt_req are ignored in IDLE.
REQ-021 SHALL transition FETCH->HALTED on halt_req when redirect_valid is low.
REQ-022 SHALL transition HALTED->FETCH on redirect_valid; start is ignored outside IDLE.
REQ-023 SHALL drive F_PC as {zeros, pc[ADDR_BITS-1:0]} from the pc register, with no combinational path from the inputs.
REQ-024 SHALL define pop as D_valid AND D_ready.
REQ-025 SHALL define fetch as (state==FETCH) AND NOT halt_req AND NOT redirect_valid AND (count<QDEPTH OR pop).
REQ-026 SHALL, on fetch, push {F_PC, Instr} at the queue tail and update pc to (pc+1) mod 2**ADDR_BITS, so that address 1023 wraps to 0.
REQ-027 SHALL take redirect_valid in FETCH or HALTED over all other events in that cycle:
- flush the queue (count<=0);
- pc<=redirect_pc mod 2**ADDR_BITS;
- perform no push.
REQ-028 SHALL treat a pop in a redirect cycle as a completed transfer, with the remaining entries discarded.
REQ-029 SHALL, on simultaneous push and pop, leave count unchanged; at full, a push with pop is legal.
REQ-030 SHALL drive D_valid = (count!=0), with D_instr/D_pc taken from the queue head register.
REQ-031 SHALL drive zeros on D_instr and D_pc when the queue is empty.
REQ-032 SHALL hold D_instr and D_pc stable while D_valid is high and D_ready is low.
REQ-033 SHALL have a latency of one cycle: the word fetched at edge N is at D_instr after edge N (visible in cycle N+1) when the queue was empty.
REQ-034 SHALL sustain a throughput of 1 instruction/cycle with D_ready held high.
REQ-035 SHALL let the queue drain in HALTED without fetching, while pc holds its value.
REQ-036 SHALL never overflow or underflow count, which stays in the range 0..QDEPTH.

Reset
REQ-037 SHALL, on reset, set state=IDLE, pc=RESET_PC, count=0, head/tail pointers=0 and queue contents=0.
REQ-038 SHALL produce the following output values during and after reset: F_PC=RESET_PC, D_valid=0, D_instr=0, D_pc=0, busy=0.
REQ-039 SHALL give reset priority over start, redirect and pop; a reset in the middle of a stream discards all entries with no further D_valid.

Structure
REQ-040 SHALL place the state encoding (IDLE/FETCH/HALTED) and the default widths (DATA_W, PC_W, ADDR_BITS) in the shared package cpu_pkg.
REQ-041 SHALL use one sub-module, fetch_queue: a parameterised synchronous FIFO with push/pop/flush, count, head outputs and {pc,instr} entries.
REQ-042 SHALL keep the PC/FSM logic in instruction_fetch, and SHALL connect it to instructionMemory only through F_PC and Instr.

Verification
REQ-043 SHALL cover the stream case: with memory words 0..3 = 0xA0..0xA3, start, and D_ready=1, D_pc/D_instr read 0/0xA0, 1/0xA1, 2/0xA2 on consecutive cycles, starting one cycle after the first FETCH cycle.
REQ-044 SHALL cover backpressure: with D_ready=0 for 5 cycles, count reaches 2, F_PC freezes at 2, and D_instr holds 0xA0; when D_ready is released, 0xA0, 0xA1, 0xA2 follow with no gap or duplicate.
REQ-045 SHALL cover redirect: with redirect_pc=0x10 while count=2 and pop=1, the popped head is consumed, the other entry is dropped, F_PC=0x10 in the next cycle, and the next D_pc=0x10.
REQ-046 SHALL cover wrap: with redirect_pc=1022 and streaming, D_pc reads 1022, 1023, 0, 1, and F_PC never exceeds 1023.
REQ-047 SHALL cover halt: on halt_req in FETCH, fetching stops, the queue drains, D_valid goes to 0 and busy goes to 0; a redirect to 5 resumes fetching with D_pc=5.
REQ-048 SHALL cover reset mid-stream: with reset asserted while count=2, the next cycle shows D_valid=0, F_PC=0 and state IDLE, and start is needed to fetch from 0 again.
